gate_response_checker: RTL and testbench

- Response-side counterpart to our gate stimulus drivers: accepts DUT output samples through a valid/ready handshake and compares each one against a preloaded expected-vector table.
- Reports the mismatch count, the index of the first failing vector, and a pass/fail verdict.
- Sits beside any gate under test (Not, And, Mux, ...) so benches and on-board self-tests are self-checking instead of relying on waveform inspection.

---
 rtl/gate_response_checker.sv | 146 ++++++++++++++
 tb/tb_gate_response_checker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_response_checker.sv
// Purpose: checks DUT output samples against a preloaded expected-vector table; reports error count, first failing index, verdict.
// Latency: each accepted sample is scored on its handshake edge; done_o/pass_o are visible the cycle after the final handshake.
// Backpressure: obs_ready_o is high for the whole RUN state, so a sample is taken every valid cycle; it is low in IDLE and DONE.
//
// Ports:
//   clk_i, rst_n_i                          clock, asynchronous active-low reset
//   exp_we_i, exp_addr_i, exp_data_i        expected-table write port (ignored while busy or out of range)
//   num_vec_i, start_i                      run length (clamped to DEPTH) and run start pulse
//   obs_valid_i, obs_data_i, obs_ready_o    observed-sample handshake
//   busy_o, done_o, pass_o                  run status and verdict
//   err_cnt_o, first_err_valid_o,
//   first_err_idx_o                         saturating mismatch count and first failing vector
module gate_response_checker #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 16,
  parameter int IDX_W = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               exp_we_i,
  input  logic [IDX_W-1:0]   exp_addr_i,
  input  logic [WIDTH-1:0]   exp_data_i,
  input  logic [IDX_W:0]     num_vec_i,
  input  logic               start_i,
  input  logic               obs_valid_i,
  input  logic [WIDTH-1:0]   obs_data_i,
  output logic               obs_ready_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [CNT_W-1:0]   err_cnt_o,
  output logic               first_err_valid_o,
  output logic [IDX_W-1:0]   first_err_idx_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W:0] DEPTH_W = (IDX_W+1)'(DEPTH);

  state_t             state_q;
  state_t             state_d;

  // idx/num_vec carry one extra bit so a full-table run (DEPTH == 2**IDX_W) is representable.
  logic [IDX_W:0]     idx_q;
  logic [IDX_W:0]     num_vec_q;
  logic [CNT_W-1:0]   err_cnt_q;
  logic               first_err_valid_q;
  logic [IDX_W-1:0]   first_err_idx_q;

  // Expected table has no reset so its contents survive a mid-run abort.
  logic [WIDTH-1:0]   tbl [DEPTH];

  logic               running;
  logic               hs;
  logic               start_acc;
  logic               last_hs;
  logic               mismatch;
  logic [IDX_W:0]     idx_inc;
  logic [IDX_W:0]     nv_clamp;

  assign running   = (state_q == S_RUN);
  assign hs        = obs_valid_i && running;
  assign start_acc = start_i && !running;
  assign idx_inc   = idx_q + (IDX_W+1)'(1);
  assign last_hs   = hs && (idx_inc == num_vec_q);
  assign mismatch  = (obs_data_i != tbl[idx_q[IDX_W-1:0]]);
  assign nv_clamp  = (num_vec_i > DEPTH_W) ? DEPTH_W : num_vec_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          // A zero-length run completes immediately with a clean verdict.
          state_d = (nv_clamp == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_hs) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Run bookkeeping: index, run length, error statistics
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idx_q             <= '0;
      num_vec_q         <= '0;
      err_cnt_q         <= '0;
      first_err_valid_q <= 1'b0;
      first_err_idx_q   <= '0;
    end else if (start_acc) begin
      num_vec_q         <= nv_clamp;
      idx_q             <= '0;
      err_cnt_q         <= '0;
      first_err_valid_q <= 1'b0;
      first_err_idx_q   <= '0;
    end else if (hs) begin
      idx_q <= idx_inc;
      if (mismatch) begin
        if (err_cnt_q != {CNT_W{1'b1}}) begin
          err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
        if (!first_err_valid_q) begin
          first_err_valid_q <= 1'b1;
          first_err_idx_q   <= idx_q[IDX_W-1:0];
        end
      end
    end
  end

  // Expected-table write port; frozen during a run so the reference cannot shift under it.
  always_ff @(posedge clk_i) begin
    if (exp_we_i && !running && ({1'b0, exp_addr_i} < DEPTH_W)) begin
      tbl[exp_addr_i] <= exp_data_i;
    end
  end

  // Status outputs decode straight from registers so reset clears them without waiting for a clock.
  assign obs_ready_o       = running;
  assign busy_o            = running;
  assign done_o            = (state_q == S_DONE);
  assign pass_o            = (state_q == S_DONE) && (err_cnt_q == '0);
  assign err_cnt_o         = err_cnt_q;
  assign first_err_valid_o = first_err_valid_q;
  assign first_err_idx_o   = first_err_idx_q;

endmodule

// File: tb/tb_gate_response_checker.sv
module tb_gate_response_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: default parameters (Not-gate style tables)
  logic       a_we = 1'b0;
  logic [3:0] a_addr = '0;
  logic [0:0] a_wdat = '0;
  logic [4:0] a_nv = '0;
  logic       a_start = 1'b0;
  logic       a_valid = 1'b0;
  logic [0:0] a_data = '0;
  logic       a_ready, a_busy, a_done, a_pass, a_fev;
  logic [7:0] a_err;
  logic [3:0] a_fei;

  gate_response_checker #(.WIDTH(1), .DEPTH(16), .IDX_W(4), .CNT_W(8)) u_a (
    .clk_i(clk), .rst_n_i(rst_n),
    .exp_we_i(a_we), .exp_addr_i(a_addr), .exp_data_i(a_wdat),
    .num_vec_i(a_nv), .start_i(a_start),
    .obs_valid_i(a_valid), .obs_data_i(a_data), .obs_ready_o(a_ready),
    .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass), .err_cnt_o(a_err),
    .first_err_valid_o(a_fev), .first_err_idx_o(a_fei)
  );

  // Instance B: small counter and table for saturation and clamping
  logic       b_we = 1'b0;
  logic [2:0] b_addr = '0;
  logic [0:0] b_wdat = '0;
  logic [3:0] b_nv = '0;
  logic       b_start = 1'b0;
  logic       b_valid = 1'b0;
  logic [0:0] b_data = '0;
  logic       b_ready, b_busy, b_done, b_pass, b_fev;
  logic [1:0] b_err;
  logic [2:0] b_fei;

  gate_response_checker #(.WIDTH(1), .DEPTH(8), .IDX_W(3), .CNT_W(2)) u_b (
    .clk_i(clk), .rst_n_i(rst_n),
    .exp_we_i(b_we), .exp_addr_i(b_addr), .exp_data_i(b_wdat),
    .num_vec_i(b_nv), .start_i(b_start),
    .obs_valid_i(b_valid), .obs_data_i(b_data), .obs_ready_o(b_ready),
    .busy_o(b_busy), .done_o(b_done), .pass_o(b_pass), .err_cnt_o(b_err),
    .first_err_valid_o(b_fev), .first_err_idx_o(b_fei)
  );

  typedef struct {
    int err;
    int fev;
    int fei;
    int pass;
    int done_cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic sb_compare(input string tag, input exp_t e, input int err, input int fev,
                            input int fei, input int pass);
    check({tag, "_done_cycle"}, cyc, e.done_cyc);
    check({tag, "_err_cnt"}, err, e.err);
    check({tag, "_first_err_valid"}, fev, e.fev);
    if (e.fev != 0) check({tag, "_first_err_idx"}, fei, e.fei);
    check({tag, "_pass"}, pass, e.pass);
  endtask

  // Monitors: score each run when done_o rises
  logic a_done_prev = 1'b0;
  logic b_done_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (a_done && !a_done_prev) begin
      check("a_sb_has_entry", (qa.size() > 0), 1);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        sb_compare("a", e, int'(a_err), int'(a_fev), int'(a_fei), int'(a_pass));
      end
    end
    a_done_prev = a_done;
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_done && !b_done_prev) begin
      check("b_sb_has_entry", (qb.size() > 0), 1);
      if (qb.size() > 0) begin
        e = qb.pop_front();
        sb_compare("b", e, int'(b_err), int'(b_fev), int'(b_fei), int'(b_pass));
      end
    end
    b_done_prev = b_done;
  end

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic push_a(input int err, input int fev, input int fei, input int pass);
    exp_t e;
    e.err = err; e.fev = fev; e.fei = fei; e.pass = pass; e.done_cyc = cyc + 1;
    qa.push_back(e);
  endtask

  task automatic push_b(input int err, input int fev, input int fei, input int pass);
    exp_t e;
    e.err = err; e.fev = fev; e.fei = fei; e.pass = pass; e.done_cyc = cyc + 1;
    qb.push_back(e);
  endtask

  task automatic a_load(input logic [3:0] addr, input logic d);
    a_we = 1'b1; a_addr = addr; a_wdat = d;
    @(posedge clk); #1;
    a_we = 1'b0;
  endtask

  task automatic a_go(input logic [4:0] nv);
    a_start = 1'b1; a_nv = nv;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic a_send(input logic d);
    a_valid = 1'b1; a_data = d;
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic b_send(input logic d);
    b_valid = 1'b1; b_data = d;
    @(posedge clk); #1;
    b_valid = 1'b0;
  endtask

  logic [3:0] not_exp;

  initial begin
    not_exp = 4'b0101;  // bit i = expected output for vector i: {1,0,1,0}

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", a_ready, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_pass", a_pass, 0);
    check("rst_err_cnt", a_err, 0);
    check("rst_first_err_valid", a_fev, 0);
    check("rst_first_err_idx", a_fei, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero-length run: straight to DONE with a pass
    push_a(0, 0, 0, 1);
    a_go(5'd0);
    check("zero_busy", a_busy, 0);
    check("zero_done", a_done, 1);
    check("zero_pass", a_pass, 1);

    // Not gate table {1,0,1,0}
    for (int i = 0; i < 4; i++) a_load(4'(i), not_exp[i]);

    // All matching, back-to-back
    a_go(5'd4);
    check("run1_busy", a_busy, 1);
    check("run1_ready", a_ready, 1);
    a_send(1'b1); a_send(1'b0); a_send(1'b1);
    push_a(0, 0, 0, 1);
    a_send(1'b0);
    check("run1_done", a_done, 1);
    check("run1_ready_done", a_ready, 0);

    // obs {1,1,1,1}: mismatches at vectors 1 and 3
    a_go(5'd4);
    a_send(1'b1); a_send(1'b1); a_send(1'b1);
    push_a(2, 1, 1, 0);
    a_send(1'b1);
    check("run2_err_cnt", a_err, 2);
    check("run2_pass", a_pass, 0);

    // Valid only every third cycle
    a_go(5'd4);
    for (int i = 0; i < 4; i++) begin
      repeat (2) @(posedge clk);
      #1;
      if (i == 3) begin
        check("gap_not_done_early", a_done, 0);
        check("gap_busy", a_busy, 1);
        push_a(0, 0, 0, 1);
      end
      a_send(not_exp[i]);
    end
    check("gap_pass", a_pass, 1);

    // start_i and a table write in mid-run must both be ignored
    a_go(5'd4);
    a_send(1'b1);
    a_start = 1'b1; a_nv = 5'd0; a_we = 1'b1; a_addr = 4'd3; a_wdat = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0; a_we = 1'b0;
    check("norestart_busy", a_busy, 1);
    a_send(1'b0); a_send(1'b1);
    push_a(0, 0, 0, 1);
    a_send(1'b0);

    // Reset mid-run after two (mismatching) handshakes
    a_go(5'd4);
    a_send(1'b0); a_send(1'b1);
    check("midrun_err_before_rst", a_err, 2);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", a_busy, 0);
    check("async_rst_ready", a_ready, 0);
    check("async_rst_err_cnt", a_err, 0);
    check("async_rst_first_err_valid", a_fev, 0);
    check("async_rst_done", a_done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table retained across reset (and unchanged by the blocked write)
    a_go(5'd4);
    a_send(1'b1); a_send(1'b0); a_send(1'b1);
    push_a(0, 0, 0, 1);
    a_send(1'b0);

    // Instance B: 8 zeros expected, all ones observed, num_vec 15 clamped to 8
    for (int i = 0; i < 8; i++) begin
      b_we = 1'b1; b_addr = 3'(i); b_wdat = 1'b0;
      @(posedge clk); #1;
    end
    b_we = 1'b0;
    b_start = 1'b1; b_nv = 4'd15;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int i = 0; i < 7; i++) b_send(1'b1);
    check("sat_busy_before_last", b_busy, 1);
    push_b(3, 1, 0, 0);
    b_send(1'b1);
    check("sat_err_cnt", b_err, 3);
    check("sat_first_err_idx", b_fei, 0);

    repeat (3) @(posedge clk);
    #1;
    check("a_sb_drained", qa.size(), 0);
    check("b_sb_drained", qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
